dc_block_ctrl: RTL and testbench

DC_BLOCK_CTRL -- requirements
Module: dc_block_ctrl

---
 rtl/dc_block_pkg.sv | 20 ++
 rtl/dc_block_ctrl_if.sv | 21 ++
 rtl/dc_settle_counter.sv | 38 +++
 rtl/dc_block_ctrl.sv | 115 +++++++++++
 tb/tb_dc_block_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dc_block_pkg.sv
// rtl/dc_block_pkg.sv - shared states, defaults and sizing helper for the DC blocker controller
package dc_block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    localparam int DEF_DATA_W           = 16;
    localparam int DEF_SETTLE_SAMPLES   = 4096;
    localparam int DEF_RESETTLE_SAMPLES = 64;

    // Counter must hold the larger of the two discard targets without wrapping
    function automatic int cnt_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/dc_block_ctrl_if.sv
// rtl/dc_block_ctrl_if.sv - sample path between host, DC blocker and controller
interface dc_block_ctrl_if #(
    parameter int DATA_W = 16
);
    logic                     sample_valid_i;
    logic                     filt_en_o;
    logic                     filt_valid_i;
    logic signed [DATA_W-1:0] filt_data_i;
    logic signed [DATA_W-1:0] data_o;
    logic                     valid_o;

    modport master (
        output sample_valid_i, filt_valid_i, filt_data_i,
        input  filt_en_o, data_o, valid_o
    );

    modport slave (
        input  sample_valid_i, filt_valid_i, filt_data_i,
        output filt_en_o, data_o, valid_o
    );
endinterface

// File: rtl/dc_settle_counter.sv
// rtl/dc_settle_counter.sv - discard counter with selectable settle/resettle target
module dc_settle_counter
    import dc_block_pkg::*;
#(
    parameter int SETTLE_SAMPLES   = DEF_SETTLE_SAMPLES,
    parameter int RESETTLE_SAMPLES = DEF_RESETTLE_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic sel_resettle,
    input  logic inc,
    output logic term
);
    localparam int CNT_W = cnt_w(SETTLE_SAMPLES, RESETTLE_SAMPLES);
    localparam logic [CNT_W-1:0] SETTLE_T   = CNT_W'(SETTLE_SAMPLES);
    localparam logic [CNT_W-1:0] RESETTLE_T = CNT_W'(RESETTLE_SAMPLES);
    localparam logic [CNT_W-1:0] MAX_T      = (SETTLE_T > RESETTLE_T) ? SETTLE_T : RESETTLE_T;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            target <= SETTLE_T;
        end else if (clr) begin
            count  <= '0;
            target <= sel_resettle ? RESETTLE_T : SETTLE_T;
        end else if (inc && (count != MAX_T)) begin
            count <= count + 1'b1;
        end
    end

    // Terminal is true while the next counted output is the last one to discard
    assign term = (count == (target - 1'b1));

endmodule

// File: rtl/dc_block_ctrl.sv
// rtl/dc_block_ctrl.sv - sequences DC blocker enable, settling discard and output gating
module dc_block_ctrl
    import dc_block_pkg::*;
#(
    parameter int DATA_W           = DEF_DATA_W,
    parameter int SETTLE_SAMPLES   = DEF_SETTLE_SAMPLES,
    parameter int RESETTLE_SAMPLES = DEF_RESETTLE_SAMPLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 freeze_i,
    dc_block_ctrl_if.slave       bus,
    output logic                 settled_o,
    output logic                 drop_err_o,
    output logic [1:0]           state_o
);
    state_t                   state;
    logic                     settled_once;
    logic                     acc_d;
    logic                     drop_err;
    logic                     valid_q;
    logic signed [DATA_W-1:0] data_q;

    logic start_ok;
    logic accepted;
    logic emit;
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_sel;
    logic cnt_term;

    assign start_ok = !stop_i && (state == ST_IDLE) && start_i;
    assign accepted = bus.sample_valid_i && bus.filt_en_o;
    // Nothing is emitted on a cycle that is leaving RUN, so valid_o never shows outside RUN
    assign emit     = (state == ST_RUN) && bus.filt_valid_i && !stop_i && !freeze_i;
    assign cnt_clr  = start_ok || (!stop_i && (state == ST_FROZEN) && !freeze_i);
    assign cnt_sel  = (state == ST_FROZEN) && settled_once;
    assign cnt_inc  = (state == ST_SETTLE) && bus.filt_valid_i && !stop_i && !freeze_i;

    dc_settle_counter #(
        .SETTLE_SAMPLES   (SETTLE_SAMPLES),
        .RESETTLE_SAMPLES (RESETTLE_SAMPLES)
    ) u_settle_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (cnt_clr),
        .sel_resettle (cnt_sel),
        .inc          (cnt_inc),
        .term         (cnt_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            settled_once <= 1'b0;
            acc_d        <= 1'b0;
            drop_err     <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            acc_d   <= accepted;
            valid_q <= emit;
            if (emit) begin
                data_q <= bus.filt_data_i;
            end
            if (start_ok) begin
                drop_err <= 1'b0;
            end else if (accepted && acc_d) begin
                drop_err <= 1'b1;
            end

            if (stop_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            state        <= ST_SETTLE;
                            settled_once <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (freeze_i) begin
                            state <= ST_FROZEN;
                        end else if (bus.filt_valid_i && cnt_term) begin
                            state        <= ST_RUN;
                            settled_once <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (freeze_i) begin
                            state <= ST_FROZEN;
                        end
                    end
                    ST_FROZEN: begin
                        if (!freeze_i) begin
                            state <= ST_SETTLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.filt_en_o = (state == ST_SETTLE) || (state == ST_RUN);
    assign bus.valid_o   = valid_q;
    assign bus.data_o    = data_q;
    assign settled_o     = (state == ST_RUN);
    assign drop_err_o    = drop_err;
    assign state_o       = state;

endmodule

// File: tb/tb_dc_block_ctrl.sv
// tb/tb_dc_block_ctrl.sv - directed self-checking bench for dc_block_ctrl
module tb_dc_block_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, stop_i, freeze_i;
    logic       settled_o, drop_err_o;
    logic [1:0] state_o;
    int         vec_cnt = 0;
    int         err_cnt = 0;

    dc_block_ctrl_if #(.DATA_W(16)) bus ();

    dc_block_ctrl #(
        .DATA_W           (16),
        .SETTLE_SAMPLES   (8),
        .RESETTLE_SAMPLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .freeze_i   (freeze_i),
        .bus        (bus),
        .settled_o  (settled_o),
        .drop_err_o (drop_err_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reach_run();
        stop_i = 1'b1; step(); stop_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bus.filt_valid_i = 1'b1; bus.filt_data_i = 16'(100 + k); step();
            bus.filt_valid_i = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; freeze_i = 1'b0;
        bus.sample_valid_i = 1'b0; bus.filt_valid_i = 1'b0; bus.filt_data_i = '0;
        step(); step();
        vec_cnt++;
        if (state_o !== 2'd0 || bus.filt_en_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 16'sd0
            || settled_o !== 1'b0 || drop_err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: state=%0d en=%b valid=%b data=%0d settled=%b drop=%b, required all 0",
                     state_o, bus.filt_en_o, bus.valid_o, bus.data_o, settled_o, drop_err_o);
        end
        rst_n = 1'b1; step();
    endtask

    task automatic test_settle_run();
        start_i = 1'b1; step(); start_i = 1'b0;
        vec_cnt++;
        if (state_o !== 2'd1 || bus.filt_en_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL settle_entry: state=%0d en=%b, required state=1 en=1", state_o, bus.filt_en_o);
        end
        for (int k = 1; k <= 12; k++) begin
            bus.filt_valid_i = 1'b1; bus.filt_data_i = 16'(k); step(); bus.filt_valid_i = 1'b0;
            vec_cnt++;
            if (bus.valid_o !== 1'(k > 8)) begin
                err_cnt++;
                $display("FAIL settle_valid k=%0d: valid=%b, required %b", k, bus.valid_o, (k > 8));
            end
            if (k > 8) begin
                vec_cnt++;
                if (bus.data_o !== 16'(k)) begin
                    err_cnt++;
                    $display("FAIL run_data k=%0d: data=%0d, required %0d", k, bus.data_o, k);
                end
            end
            vec_cnt++;
            if (state_o !== ((k >= 8) ? 2'd2 : 2'd1)) begin
                err_cnt++;
                $display("FAIL settle_state k=%0d: state=%0d, required %0d", k, state_o, (k >= 8) ? 2 : 1);
            end
            step();
        end
        vec_cnt++;
        if (settled_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.data_o !== 16'sd12) begin
            err_cnt++;
            $display("FAIL run_hold: settled=%b valid=%b data=%0d, required settled=1 valid=0 data=12",
                     settled_o, bus.valid_o, bus.data_o);
        end
    endtask

    task automatic test_freeze_run();
        freeze_i = 1'b1; step();
        vec_cnt++;
        if (state_o !== 2'd3 || bus.filt_en_o !== 1'b0 || settled_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL freeze_entry: state=%0d en=%b settled=%b, required state=3 en=0 settled=0",
                     state_o, bus.filt_en_o, settled_o);
        end
        for (int c = 1; c < 20; c++) begin
            bus.filt_valid_i = (c % 4 == 0); bus.filt_data_i = 16'(200 + c); step();
            vec_cnt++;
            if (bus.valid_o !== 1'b0 || state_o !== 2'd3) begin
                err_cnt++;
                $display("FAIL frozen_quiet c=%0d: valid=%b state=%0d, required valid=0 state=3", c, bus.valid_o, state_o);
            end
        end
        bus.filt_valid_i = 1'b0; freeze_i = 1'b0; step();
        vec_cnt++;
        if (state_o !== 2'd1) begin
            err_cnt++;
            $display("FAIL unfreeze_state: state=%0d, required 1", state_o);
        end
        for (int k = 1; k <= 3; k++) begin
            bus.filt_valid_i = 1'b1; bus.filt_data_i = 16'sh0050 + 16'(k); step(); bus.filt_valid_i = 1'b0;
            vec_cnt++;
            if (state_o !== ((k >= 2) ? 2'd2 : 2'd1) || bus.valid_o !== 1'(k == 3)) begin
                err_cnt++;
                $display("FAIL resettle k=%0d: state=%0d valid=%b, required state=%0d valid=%b",
                         k, state_o, bus.valid_o, (k >= 2) ? 2 : 1, (k == 3));
            end
            step();
        end
        vec_cnt++;
        if (bus.data_o !== 16'sh0053 || drop_err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL resettle_data: data=%0h drop=%b, required data=53 drop=0", bus.data_o, drop_err_o);
        end
    endtask

    task automatic test_freeze_settle();
        stop_i = 1'b1; step(); stop_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.filt_valid_i = 1'b1; step(); bus.filt_valid_i = 1'b0; step();
        end
        freeze_i = 1'b1; step(); step(); freeze_i = 1'b0; step();
        for (int k = 1; k <= 8; k++) begin
            bus.filt_valid_i = 1'b1; bus.filt_data_i = 16'(k); step(); bus.filt_valid_i = 1'b0;
            vec_cnt++;
            if (state_o !== ((k == 8) ? 2'd2 : 2'd1) || bus.valid_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL full_resettle k=%0d: state=%0d valid=%b, required state=%0d valid=0",
                         k, state_o, bus.valid_o, (k == 8) ? 2 : 1);
            end
            step();
        end
    endtask

    task automatic test_drop_err();
        bus.sample_valid_i = 1'b1; step(); bus.sample_valid_i = 1'b0; step();
        vec_cnt++;
        if (drop_err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_single: drop=%b, required 0", drop_err_o);
        end
        bus.sample_valid_i = 1'b1; step(); step(); bus.sample_valid_i = 1'b0;
        vec_cnt++;
        if (drop_err_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL drop_set: drop=%b, required 1", drop_err_o);
        end
        start_i = 1'b1; step(); start_i = 1'b0;
        stop_i = 1'b1; step(); stop_i = 1'b0;
        vec_cnt++;
        if (drop_err_o !== 1'b1 || state_o !== 2'd0) begin
            err_cnt++;
            $display("FAIL drop_sticky: drop=%b state=%0d, required drop=1 state=0", drop_err_o, state_o);
        end
        start_i = 1'b1; step(); start_i = 1'b0;
        vec_cnt++;
        if (drop_err_o !== 1'b0 || state_o !== 2'd1) begin
            err_cnt++;
            $display("FAIL drop_clear: drop=%b state=%0d, required drop=0 state=1", drop_err_o, state_o);
        end
    endtask

    task automatic test_stop_freeze();
        reach_run();
        stop_i = 1'b1; freeze_i = 1'b1; bus.filt_valid_i = 1'b1; bus.filt_data_i = 16'sh0077; step();
        stop_i = 1'b0; freeze_i = 1'b0; bus.filt_valid_i = 1'b0;
        vec_cnt++;
        if (state_o !== 2'd0 || bus.filt_en_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL stop_over_freeze: state=%0d en=%b valid=%b, required 0 0 0",
                     state_o, bus.filt_en_o, bus.valid_o);
        end
    endtask

    task automatic test_reset_mid();
        reach_run();
        bus.filt_valid_i = 1'b1; bus.filt_data_i = 16'sh1234; step();
        bus.filt_data_i = 16'sh4321; #2 rst_n = 1'b0; #1;
        vec_cnt++;
        if (state_o !== 2'd0 || bus.filt_en_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 16'sd0
            || settled_o !== 1'b0 || drop_err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid: state=%0d en=%b valid=%b data=%0h settled=%b drop=%b, required all 0",
                     state_o, bus.filt_en_o, bus.valid_o, bus.data_o, settled_o, drop_err_o);
        end
        step(); bus.filt_valid_i = 1'b0; rst_n = 1'b1; step(); step();
        vec_cnt++;
        if (state_o !== 2'd0 || bus.valid_o !== 1'b0 || bus.data_o !== 16'sd0) begin
            err_cnt++;
            $display("FAIL reset_release: state=%0d valid=%b data=%0h, required 0 0 0",
                     state_o, bus.valid_o, bus.data_o);
        end
    endtask

    initial begin
        test_reset();
        test_settle_run();
        test_freeze_run();
        test_freeze_settle();
        test_drop_err();
        test_stop_freeze();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
